carry_in_bin: RTL and testbench
===============================

CARRY_IN_BIN -- requirements
Module: carry_in_bin

Interface
REQ-001 Parameter WORD_WIDTH, default 9; width of A, B, sum, carries; SHALL be >= 2.
REQ-002 Parameter EXT_WIDTH, default 9; width of carries_ext; SHALL be >= 1.
REQ-003 Parameter SIGNED, default 0; 0 zero-extends carries_ext, 1 sign-extends it.
REQ-004 clock  input  1  sole clock, rising edge; all state changes on this edge.
REQ-005 clear_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  A, B, sum (and carry_out) are valid this cycle.
REQ-007 A  input  WORD_WIDTH  first addend.
REQ-008 B  input  WORD_WIDTH  second addend, already bit-negated for subtraction.
REQ-009 sum  input  WORD_WIDTH  result of A + B + carry-in.
REQ-010 carry_out  input  1  carry out of the MSB; present only when CARRY_IN_BIN_OVERFLOW_EN is defined.
REQ-011 out_valid  output  1  registered outputs hold a new result.
REQ-012 carries  output  WORD_WIDTH  registered carry into each bit position.
REQ-013 carries_ext  output  EXT_WIDTH  registered carries, width-adjusted.
REQ-014 overflow  output  1  registered signed overflow; present only when CARRY_IN_BIN_OVERFLOW_EN is defined.

Function
REQ-015 Combinational carry vector c SHALL be A XOR B XOR sum, bitwise; c[0] equals the adder carry-in.
REQ-016 Width adjust: EXT_WIDTH > WORD_WIDTH pads the MSBs with zeros (SIGNED=0) or copies of c[WORD_WIDTH-1] (SIGNED=1).
REQ-017 Width adjust: EXT_WIDTH = WORD_WIDTH passes c unchanged; EXT_WIDTH < WORD_WIDTH keeps the EXT_WIDTH LSBs of c.
REQ-018 On a clock edge with in_valid=1, carries, carries_ext (and overflow) SHALL load the new values, with 1-cycle latency.
REQ-019 out_valid SHALL be in_valid delayed by one cycle.
REQ-020 With in_valid=0, carries, carries_ext and overflow SHALL hold their previous values.
REQ-021 No back-pressure: every valid input produces exactly one out_valid pulse one cycle later.
REQ-022 Back-to-back valid inputs SHALL give back-to-back results.
REQ-023 Arithmetic is purely bitwise and unsigned; there are no width mismatches and no implicit sign extension.

Reset
REQ-024 While clear_n=0: out_valid, carries, carries_ext and overflow SHALL be 0, regardless of clock.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-026 The first capture after reset is at the first rising edge with clear_n=1 and in_valid=1.

Configuration
REQ-027 Macro CARRY_IN_BIN_OVERFLOW_EN defined: carry_out input and overflow output exist, with overflow = (c[WORD_WIDTH-1] != carry_out), registered as in REQ-018.
REQ-028 Macro CARRY_IN_BIN_OVERFLOW_EN undefined: carry_out and overflow ports are absent, and all other behaviour is identical.

Verification
REQ-029 WORD_WIDTH=9; A=0x0FF, B=0x001, sum=0x100, in_valid=1 -> next cycle carries=0x1FE, out_valid=1.
REQ-030 Subtract 5-3 with carry-in 1: A=0x005, B=0x1FC, sum=0x002 -> carries=0x1FB (bit0=1).
REQ-031 EXT_WIDTH=12 with carries=0x1FE -> carries_ext=0xFFE when SIGNED=1, 0x1FE when SIGNED=0.
REQ-032 OVERFLOW_EN defined; A=0x0FF, B=0x001, sum=0x100, carry_out=0 -> overflow=1; A=0x005, B=0x1FC, sum=0x002, carry_out=1 -> overflow=0.
REQ-033 in_valid=0 for 3 cycles after a result -> outputs held and out_valid=0; clear_n pulsed low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/carry_in_bin.sv
// Recovers the per-bit carry-in vector of an adder from its operands and result.
// Latency: 1 cycle from in_valid to out_valid; results hold while in_valid is low.
// Backpressure: none; every valid input yields exactly one out_valid pulse.
//
// Ports:
//   clock, clear_n        - rising-edge clock, asynchronous active-low reset
//   in_valid, A, B, sum   - adder operands (B already inverted for subtract) and result
//   carry_out             - adder MSB carry-out (only with CARRY_IN_BIN_OVERFLOW_EN)
//   out_valid             - registered results updated this cycle
//   carries               - registered carry into each bit position
//   carries_ext           - carries resized to EXT_WIDTH (zero- or sign-extended, or truncated)
//   overflow              - registered signed overflow (only with CARRY_IN_BIN_OVERFLOW_EN)
//
// Optional feature macro: CARRY_IN_BIN_OVERFLOW_EN adds carry_out and overflow.

module carry_in_bin #(
    parameter int WORD_WIDTH = 9,
    parameter int EXT_WIDTH  = 9,
    parameter int SIGNED     = 0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] A,
    input  logic [WORD_WIDTH-1:0] B,
    input  logic [WORD_WIDTH-1:0] sum,
`ifdef CARRY_IN_BIN_OVERFLOW_EN
    input  logic                  carry_out,
    output logic                  overflow,
`endif
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] carries,
    output logic [EXT_WIDTH-1:0]  carries_ext
);

    // sum[i] = A[i] ^ B[i] ^ cin[i], so the carry into each bit falls out directly.
    logic [WORD_WIDTH-1:0] c;
    logic [EXT_WIDTH-1:0]  c_ext;

    assign c = A ^ B ^ sum;

    generate
        if (EXT_WIDTH > WORD_WIDTH) begin : g_pad
            logic [EXT_WIDTH-WORD_WIDTH-1:0] pad;
            // Sign extension replicates the carry into the MSB position.
            assign pad   = (SIGNED != 0) ? {(EXT_WIDTH-WORD_WIDTH){c[WORD_WIDTH-1]}}
                                         : '0;
            assign c_ext = {pad, c};
        end else begin : g_trunc
            assign c_ext = c[EXT_WIDTH-1:0];
        end
    endgenerate

    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] carries_q, carries_d;
    logic [EXT_WIDTH-1:0]  carries_ext_q, carries_ext_d;

    always_comb begin
        out_valid_d   = in_valid;
        carries_d     = carries_q;
        carries_ext_d = carries_ext_q;
        if (in_valid) begin
            carries_d     = c;
            carries_ext_d = c_ext;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            out_valid_q   <= 1'b0;
            carries_q     <= '0;
            carries_ext_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            carries_q     <= carries_d;
            carries_ext_q <= carries_ext_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign carries     = carries_q;
    assign carries_ext = carries_ext_q;

`ifdef CARRY_IN_BIN_OVERFLOW_EN
    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (in_valid) begin
            overflow_d = c[WORD_WIDTH-1] ^ carry_out;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_carry_in_bin.sv
// Self-checking bench for carry_in_bin: three instances share one stimulus stream
// (12-bit sign-extended, 12-bit zero-extended, 6-bit truncated carries_ext).

module tb_carry_in_bin;

    logic       clock;
    logic       clear_n;
    logic       in_valid;
    logic [8:0] a_in, b_in, sum_in;
    logic       carry_out;

    logic        ov_s, ov_u, ov_t;
    logic [8:0]  car_s, car_u, car_t;
    logic [11:0] ext_s, ext_u;
    logic [5:0]  ext_t;
`ifdef CARRY_IN_BIN_OVERFLOW_EN
    logic        ovf_s, ovf_u, ovf_t;
`endif

    carry_in_bin #(.WORD_WIDTH(9), .EXT_WIDTH(12), .SIGNED(1)) dut_s (
        .clock(clock), .clear_n(clear_n), .in_valid(in_valid),
        .A(a_in), .B(b_in), .sum(sum_in),
`ifdef CARRY_IN_BIN_OVERFLOW_EN
        .carry_out(carry_out), .overflow(ovf_s),
`endif
        .out_valid(ov_s), .carries(car_s), .carries_ext(ext_s));

    carry_in_bin #(.WORD_WIDTH(9), .EXT_WIDTH(12), .SIGNED(0)) dut_u (
        .clock(clock), .clear_n(clear_n), .in_valid(in_valid),
        .A(a_in), .B(b_in), .sum(sum_in),
`ifdef CARRY_IN_BIN_OVERFLOW_EN
        .carry_out(carry_out), .overflow(ovf_u),
`endif
        .out_valid(ov_u), .carries(car_u), .carries_ext(ext_u));

    carry_in_bin #(.WORD_WIDTH(9), .EXT_WIDTH(6), .SIGNED(1)) dut_t (
        .clock(clock), .clear_n(clear_n), .in_valid(in_valid),
        .A(a_in), .B(b_in), .sum(sum_in),
`ifdef CARRY_IN_BIN_OVERFLOW_EN
        .carry_out(carry_out), .overflow(ovf_t),
`endif
        .out_valid(ov_t), .carries(car_t), .carries_ext(ext_t));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [8:0]  c;
        logic [11:0] es;
        logic [11:0] eu;
        logic [5:0]  et;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Independent model: carry = a^b^s, then resize by hand.
    function automatic exp_t model(input logic [8:0] a, input logic [8:0] b,
                                   input logic [8:0] s, input logic co);
        exp_t e;
        e.c  = a ^ b ^ s;
        e.es = {{3{e.c[8]}}, e.c};
        e.eu = {3'b000, e.c};
        e.et = e.c[5:0];
        e.ov = (e.c[8] != co);
        return e;
    endfunction

    task automatic compare_all(input string tag, input exp_t e);
        check({tag, ".car_s"}, 32'(car_s), 32'(e.c));
        check({tag, ".car_t"}, 32'(car_t), 32'(e.c));
        check({tag, ".ext_s"}, 32'(ext_s), 32'(e.es));
        check({tag, ".ext_u"}, 32'(ext_u), 32'(e.eu));
        check({tag, ".ext_t"}, 32'(ext_t), 32'(e.et));
`ifdef CARRY_IN_BIN_OVERFLOW_EN
        check({tag, ".ovf_s"}, 32'(ovf_s), 32'(e.ov));
        check({tag, ".ovf_u"}, 32'(ovf_u), 32'(e.ov));
        check({tag, ".ovf_t"}, 32'(ovf_t), 32'(e.ov));
`endif
    endtask

    task automatic check_valid(input string tag, input logic v);
        check({tag, ".ov_s"}, 32'(ov_s), 32'(v));
        check({tag, ".ov_u"}, 32'(ov_u), 32'(v));
        check({tag, ".ov_t"}, 32'(ov_t), 32'(v));
    endtask

    // Called at a negedge: drive one cycle, then check after the following posedge.
    task automatic cycle(input string tag, input logic [8:0] a, input logic [8:0] b,
                         input logic [8:0] s, input logic v, input logic co);
        a_in = a; b_in = b; sum_in = s; in_valid = v; carry_out = co;
        if (v) exp_q.push_back(model(a, b, s, co));
        @(negedge clock);
        check_valid(tag, v);
        if (ov_s === 1'b1 && exp_q.size() > 0) held = exp_q.pop_front();
        compare_all(tag, held);
    endtask

    exp_t zero_e;

    initial begin
        zero_e = '{c: 9'h0, es: 12'h0, eu: 12'h0, et: 6'h0, ov: 1'b0};
        held = zero_e;
        clear_n = 1'b0; in_valid = 1'b0;
        a_in = '0; b_in = '0; sum_in = '0; carry_out = 1'b0;

        // Reset state before any clock edge, then with a valid edge while in reset.
        #2;
        check_valid("rst0", 1'b0);
        compare_all("rst0", zero_e);
        a_in = 9'h0FF; b_in = 9'h001; sum_in = 9'h100; in_valid = 1'b1;
        @(negedge clock);
        check_valid("rst1", 1'b0);
        compare_all("rst1", zero_e);
        clear_n = 1'b1;

        // Directed vectors: 0xFF+1 carry ripple, then 5-3 with carry-in.
        cycle("add",  9'h0FF, 9'h001, 9'h100, 1'b1, 1'b0);
        check("add.direct", 32'(car_s), 32'h1FE);
        check("add.sext",   32'(ext_s), 32'hFFE);
        check("add.zext",   32'(ext_u), 32'h1FE);
        cycle("sub",  9'h005, 9'h1FC, 9'h002, 1'b1, 1'b1);
        check("sub.direct", 32'(car_s), 32'h1FB);
        check("sub.sext",   32'(ext_s), 32'hFFB);

        // Idle cycles: results held, out_valid low.
        for (int i = 0; i < 3; i++) cycle("idle", 9'h1AA, 9'h155, 9'h0F0, 1'b0, 1'b1);

        // MSB carry clear: sign extension must fill with zeros.
        cycle("pos",  9'h003, 9'h005, 9'h008, 1'b1, 1'b0);
        check("pos.sext", 32'(ext_s), 32'h00E);

        // Back-to-back realistic adds with random carry-in.
        for (int i = 0; i < 10; i++) begin
            logic [8:0] a, b;
            logic       cin;
            logic [9:0] full;
            a    = 9'($urandom_range(0, 511));
            b    = 9'($urandom_range(0, 511));
            cin  = 1'($urandom_range(0, 1));
            full = 10'(a) + 10'(b) + 10'(cin);
            cycle("rnd", a, b, full[8:0], 1'b1, full[9]);
            check("rnd.cin", 32'(car_s[0]), 32'(cin));
        end
        cycle("gap", 9'h000, 9'h000, 9'h000, 1'b0, 1'b0);

        // Mid-stream reset: capture, then clear between edges; outputs drop at once.
        a_in = 9'h0FF; b_in = 9'h001; sum_in = 9'h100; in_valid = 1'b1; carry_out = 1'b0;
        @(posedge clock);
        #2;
        check_valid("pre_clr", 1'b1);
        clear_n = 1'b0;
        #1;
        check_valid("clr", 1'b0);
        compare_all("clr", zero_e);
        exp_q.delete();
        held = zero_e;
        @(negedge clock);
        check_valid("clr_hold", 1'b0);
        compare_all("clr_hold", zero_e);
        clear_n = 1'b1;

        // First capture after reset release.
        cycle("post", 9'h005, 9'h1FC, 9'h002, 1'b1, 1'b1);
        cycle("tail", 9'h000, 9'h000, 9'h000, 1'b0, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
